// File: rtl/mem_arbiter.sv
// Shares one word RAM between fetch and load/store: one access per cycle, registered responses, 2-cycle RMW for sub-word stores.
// Fixed data-over-fetch priority by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] rmw_addr_q, rmw_addr_d;
  logic [31:0] rmw_data_q, rmw_data_d;

  logic        idle;
  logic        d_misal;
  logic        d_load, d_wstore, d_sstore;
  logic [31:0] merged;

  assign idle = (state_q == IDLE);

  always_comb begin
    d_misal = 1'b0;
    case (d_size)
      2'b00:   d_misal = 1'b0;
      2'b01:   d_misal = d_addr[0];
      2'b10:   d_misal = |d_addr[1:0];
      default: d_misal = 1'b1;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  // last_d_q: 1 when the last grant went to the data port; on a tie the other port wins.
  logic last_d_q, last_d_d;

  assign d_gnt    = idle & d_req & (~if_req | ~last_d_q);
  assign if_gnt   = idle & if_req & (~d_req | last_d_q);
  assign last_d_d = d_gnt ? 1'b1 : (if_gnt ? 1'b0 : last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign d_gnt  = idle & d_req;
  assign if_gnt = idle & if_req & ~d_req;
`endif

  assign d_load   = d_gnt & ~d_misal & ~d_we;
  assign d_wstore = d_gnt & ~d_misal & d_we & (d_size == 2'b10);
  assign d_sstore = d_gnt & ~d_misal & d_we & (d_size != 2'b10);

  // Old word from the RAM with the addressed byte/half lane replaced.
  always_comb begin
    merged = mem_rdata;
    if (d_size == 2'b00) begin
      case (d_addr[1:0])
        2'd0:    merged[7:0]   = d_wdata[7:0];
        2'd1:    merged[15:8]  = d_wdata[7:0];
        2'd2:    merged[23:16] = d_wdata[7:0];
        default: merged[31:24] = d_wdata[7:0];
      endcase
    end else if (d_addr[1]) begin
      merged[31:16] = d_wdata[15:0];
    end else begin
      merged[15:0] = d_wdata[15:0];
    end
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (state_q == RMW_WR) begin
      mem_we    = 1'b1;
      mem_addr  = rmw_addr_q;
      mem_wdata = rmw_data_q;
    end else if (d_load | d_sstore) begin
      mem_re   = 1'b1;
      mem_addr = d_addr;
    end else if (d_wstore) begin
      mem_we    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_re   = 1'b1;
      mem_addr = if_addr;
    end
  end

  always_comb begin
    state_d     = IDLE;
    if_rvalid_d = if_gnt;
    if_rdata_d  = if_gnt ? mem_rdata : 32'h0;
    d_rvalid_d  = (d_gnt & ~d_sstore) | (state_q == RMW_WR);
    d_err_d     = d_gnt & d_misal;
    d_rdata_d   = d_load ? mem_rdata : 32'h0;
    rmw_addr_d  = rmw_addr_q;
    rmw_data_d  = rmw_data_q;
    if (d_sstore) begin
      state_d    = RMW_WR;
      rmw_addr_d = d_addr;
      rmw_data_d = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
      rmw_addr_q  <= 32'h0;
      rmw_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_data_q  <= rmw_data_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed sequences, a vector table of data accesses, and random traffic against a reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:255];
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_dat;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic        re;
    logic        mwe;
    int          lat;
  } vec_t;

  typedef struct {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } resp_t;

  vec_t        tbl [12];
  resp_t       pd [3];
  resp_t       pi [2];
  int          idx;
  logic [31:0] old;
  logic [3:0]  pat_if, pat_d;
  logic        busy, busy_n, last_data, e_if, e_d, g_if, g_d;
  int          mism;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
    if (bd_we) ram[bd_idx] <= bd_dat;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [1:0] size,
                                        input logic [1:0] a, input logic [31:0] wd);
    int          sh;
    logic [31:0] mask;
    if (size == 2'b10) return wd;
    sh   = (size == 2'b00) ? 8 * int'(a) : 16 * int'(a[1]);
    mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (o & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] a);
    int ai;
    ai = int'(a);
    return (size == 2'b11) || (size == 2'b01 && ai % 2 != 0) || (size == 2'b10 && ai % 4 != 0);
  endfunction

  task automatic bd_write(input int i, input logic [31:0] v);
    bd_we  = 1'b1;
    bd_idx = i[9:0];
    bd_dat = v;
    ref_mem[i] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_dat = '0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;

    tbl[0]  = '{1'b0, 2'd2, 12'h010, 32'h0,         1'b0, 1'b1, 1'b0, 1};
    tbl[1]  = '{1'b0, 2'd0, 12'h013, 32'h0,         1'b0, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b0, 2'd1, 12'h016, 32'h0,         1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{1'b0, 2'd1, 12'h011, 32'h0,         1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{1'b0, 2'd2, 12'h012, 32'h0,         1'b1, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b0, 2'd3, 12'h020, 32'h0,         1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b1, 2'd2, 12'h024, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 1};
    tbl[7]  = '{1'b1, 2'd0, 12'h029, 32'h0000_00C3, 1'b0, 1'b1, 1'b0, 2};
    tbl[8]  = '{1'b1, 2'd1, 12'h02E, 32'hFFFF_BEEF, 1'b0, 1'b1, 1'b0, 2};
    tbl[9]  = '{1'b1, 2'd1, 12'h201, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b1, 2'd2, 12'h036, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b1, 2'd3, 12'h040, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1};

    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) bd_write(i, $urandom);
    bd_write(16, 32'hDEAD_BEEF);
    bd_write(64, 32'h1122_3344);
    bd_write(128, 32'h5566_7788);
    bd_write(192, 32'hCAFE_F00D);

    // Reset release with no requests
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt", if_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0); chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rvalid", d_rvalid, 0); chk("rst_d_err", d_err, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_we", mem_we, 0);     chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_mem_we", mem_we, 0); chk("idle_mem_re", mem_re, 0);
    @(posedge clk); #1;

    // Fetch
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("fetch_gnt", if_gnt, 1); chk("fetch_d_gnt", d_gnt, 0);
    chk("fetch_mem_re", mem_re, 1); chk("fetch_mem_addr", mem_addr, 32'h40);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    chk("fetch_rvalid", if_rvalid, 1); chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Byte store 0xAA at 0x102, fetch queued during the write phase, then readback
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h102; d_wdata = 32'h1234_56AA;
    @(negedge clk);
    chk("sb_gnt", d_gnt, 1); chk("sb_mem_re", mem_re, 1); chk("sb_mem_we0", mem_we, 0);
    @(posedge clk); #1; d_req = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("sb_mem_we", mem_we, 1); chk("sb_mem_wdata", mem_wdata, 32'h11AA_3344);
    chk("sb_mem_idx", {22'h0, mem_addr[11:2]}, 32'h40);
    chk("sb_rmw_if_gnt", if_gnt, 0); chk("sb_rmw_d_rvalid", d_rvalid, 0);
    ref_mem[64] = 32'h11AA_3344;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_rvalid", d_rvalid, 1); chk("sb_err", d_err, 0); chk("sb_rdata", d_rdata, 0);
    chk("sb_next_if_gnt", if_gnt, 1);
    @(posedge clk); #1; if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h100;
    @(negedge clk);
    chk("sb_ld_gnt", d_gnt, 1);
    @(posedge clk); #1; d_req = 1'b0;
    @(negedge clk);
    chk("sb_ld_rvalid", d_rvalid, 1); chk("sb_ld_rdata", d_rdata, 32'h11AA_3344);
    @(posedge clk); #1;

    // Contention: both ports held for 4 cycles
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat_if[i] = if_gnt; pat_d[i] = d_gnt;
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("cont_if_pattern", {28'h0, pat_if}, 32'h5);
    chk("cont_d_pattern", {28'h0, pat_d}, 32'hA);
`else
    chk("cont_if_pattern", {28'h0, pat_if}, 32'h0);
    chk("cont_d_pattern", {28'h0, pat_d}, 32'hF);
`endif
    @(posedge clk); #1;

    // Vector table of single data accesses
    for (int i = 0; i < 12; i++) begin
      d_req = 1'b1; d_we = tbl[i].we; d_size = tbl[i].size;
      d_addr = {20'h0, tbl[i].addr}; d_wdata = tbl[i].wdata;
      idx = int'(tbl[i].addr[9:2]);
      old = ref_mem[idx];
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), d_gnt, 1);
      chk($sformatf("vec%0d_mem_re", i), mem_re, tbl[i].re);
      chk($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].mwe);
      @(posedge clk); #1; d_req = 1'b0;
      if (tbl[i].lat == 2) begin
        @(negedge clk);
        chk($sformatf("vec%0d_rmw_we", i), mem_we, 1);
        chk($sformatf("vec%0d_rmw_wdata", i), mem_wdata, merge(old, tbl[i].size, tbl[i].addr[1:0], tbl[i].wdata));
        chk($sformatf("vec%0d_early_rvalid", i), d_rvalid, 0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk($sformatf("vec%0d_rvalid", i), d_rvalid, 1);
      chk($sformatf("vec%0d_err", i), d_err, tbl[i].err);
      chk($sformatf("vec%0d_rdata", i), d_rdata, (!tbl[i].we && !tbl[i].err) ? old : 32'h0);
      if (tbl[i].we && !tbl[i].err) ref_mem[idx] = merge(old, tbl[i].size, tbl[i].addr[1:0], tbl[i].wdata);
      @(posedge clk); #1;
    end
    chk("misal_ram_unchanged", ram[128], 32'h5566_7788);

    // Reset asserted during the write phase of a half store
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 32'h300; d_wdata = 32'h0000_BEEF;
    @(negedge clk);
    chk("rr_gnt", d_gnt, 1); chk("rr_mem_re", mem_re, 1);
    @(posedge clk); #1; d_req = 1'b0;
    @(negedge clk);
    chk("rr_mem_we_before", mem_we, 1);
    #1 rst_n = 1'b0;
    #1 chk("rr_mem_we_dropped", mem_we, 0);
    @(posedge clk); #1;
    chk("rr_ram_kept", ram[192], 32'hCAFE_F00D);
    @(negedge clk);
    chk("rr_no_rvalid", d_rvalid, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rr_no_rvalid_after", d_rvalid, 0);
    @(posedge clk); #1;

    // Random traffic against the reference model
    busy = 1'b0; last_data = 1'b1; g_if = 1'b0; g_d = 1'b0;
    for (int k = 0; k < 3; k++) pd[k] = '{1'b0, 1'b0, 32'h0};
    for (int k = 0; k < 2; k++) pi[k] = '{1'b0, 1'b0, 32'h0};
    for (int c = 0; c < 3000; c++) begin
      if (!if_req || g_if) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      end
      if (!d_req || g_d) begin
        d_req   = ($urandom_range(0, 1) != 0);
        d_we    = ($urandom_range(0, 1) != 0);
        d_size  = 2'($urandom_range(0, 3));
        d_addr  = {22'h0, 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(0, 3))};
        d_wdata = $urandom;
      end
      @(negedge clk);
      e_if = 1'b0; e_d = 1'b0; busy_n = 1'b0;
      if (!busy) begin
`ifdef MEM_ARB_RR_EN
        if (if_req && d_req) begin
          e_d  = !last_data;
          e_if = last_data;
        end else begin
          e_d  = d_req;
          e_if = if_req;
        end
`else
        e_d  = d_req;
        e_if = if_req && !d_req;
`endif
      end
      chk("rnd_if_gnt", if_gnt, e_if);
      chk("rnd_d_gnt", d_gnt, e_d);
      chk("rnd_d_rvalid", d_rvalid, pd[0].vld);
      if (pd[0].vld) begin
        chk("rnd_d_err", d_err, pd[0].err);
        chk("rnd_d_rdata", d_rdata, pd[0].dat);
      end
      chk("rnd_if_rvalid", if_rvalid, pi[0].vld);
      if (pi[0].vld) chk("rnd_if_rdata", if_rdata, pi[0].dat);
      if (e_if) begin
        pi[1] = '{1'b1, 1'b0, ref_mem[if_addr[9:2]]};
        last_data = 1'b0;
      end
      if (e_d) begin
        last_data = 1'b1;
        idx = int'(d_addr[9:2]);
        if (is_bad(d_size, d_addr[1:0])) begin
          pd[1] = '{1'b1, 1'b1, 32'h0};
        end else if (!d_we) begin
          pd[1] = '{1'b1, 1'b0, ref_mem[idx]};
        end else if (d_size == 2'b10) begin
          ref_mem[idx] = d_wdata;
          pd[1] = '{1'b1, 1'b0, 32'h0};
        end else begin
          ref_mem[idx] = merge(ref_mem[idx], d_size, d_addr[1:0], d_wdata);
          pd[2] = '{1'b1, 1'b0, 32'h0};
          busy_n = 1'b1;
        end
      end
      g_if = e_if; g_d = e_d; busy = busy_n;
      pd[0] = pd[1]; pd[1] = pd[2]; pd[2] = '{1'b0, 1'b0, 32'h0};
      pi[0] = pi[1]; pi[1] = '{1'b0, 1'b0, 32'h0};
      @(posedge clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_final_mismatch_words", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory controller between the core's instruction-fetch port and load/store port and the shared 4 KiB word RAM. It arbitrates one access per cycle and registers read responses. Sub-word stores are performed as a two-cycle read-modify-write, since the RAM has only whole-word write enable. Misaligned data accesses are rejected with an error response.

## Interface
- No parameters. Address width is 32 bits; the RAM decodes addr[11:2].
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until granted
- if_addr  in  32  fetch byte address (word-aligned; bits [1:0] ignored)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  32  fetch word
- d_req  in  1  data request; held with d_we, d_size, d_addr and d_wdata until granted
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data transaction complete (one-cycle pulse)
- d_rdata  out  32  full load word, unaligned; core extracts the lane. 0 for stores and errors.
- d_err  out  1  valid with d_rvalid; 1 = misaligned or illegal access
- mem_we, mem_re  out  1  RAM write enable and read enable
- mem_addr, mem_wdata  out  32  RAM address and write data
- mem_rdata  in  32  RAM combinational read data

## Operation
- **States**
  - IDLE: accepts one request per cycle.
  - RMW_WR: write phase of a sub-word store; no grants are issued.
- **Arbitration in IDLE**
  - Fixed priority, data over fetch. A continuous d_req stream starves fetch; this is accepted behaviour.
  - if_gnt/d_gnt are combinational from if_req/d_req and state. At most one grant per cycle.
- **Misaligned or illegal data access**
  - Conditions: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Behaviour: granted; no mem_re or mem_we; next cycle d_rvalid=1 and d_err=1.
- **Load**
  - Grant cycle: mem_re=1, mem_addr=d_addr, mem_rdata registered.
  - Next cycle: d_rvalid=1, d_rdata=word.
- **Fetch**
  - Identical to a load, using the if_* signals. Fetch never errors.
- **Word store**
  - Grant cycle: mem_we=1, mem_wdata=d_wdata.
  - Next cycle: d_rvalid=1, d_err=0.
- **Byte or half store (RMW)**
  - Grant cycle: mem_re=1. Merged word is registered: old word with lane replaced. Byte lane is addr[1:0], data from d_wdata[7:0]. Half lane is addr[1], data from d_wdata[15:0]. Address is also registered.
  - Next state: RMW_WR.
  - RMW_WR: mem_we=1 with the registered address and merged data. Returns to IDLE.
  - Cycle after RMW_WR: d_rvalid=1. In that cycle, IDLE may already grant the next request.
- mem_* outputs are 0 whenever no access is in progress.

## Timing
- **Reset values** (all registers reset asynchronously): state=IDLE; if_rvalid, d_rvalid, d_err, if_rdata, d_rdata = 0; mem_we, mem_re = 0. Arbitration pointer, when compiled in, resets to favour fetch.
- **Reset during RMW_WR:** mem_we drops immediately; the store is lost and RAM is unmodified; no d_rvalid.
- **Latency, grant to rvalid:** 1 cycle for loads, fetches, word stores and errors; 2 cycles for sub-word stores.
- **Throughput:** 1 access per cycle, except sub-word stores, which take 2.
- **Simultaneous if_req and d_req:** exactly one is granted. The loser keeps its request asserted and is granted in a later cycle.
- **Request during RMW_WR:** both grants are 0 that cycle.
- **Handshake:** requester inputs may change in the cycle after a grant.

## Configuration
- **MEM_ARB_RR_EN defined:** round-robin arbitration. A 1-bit pointer holds the last port granted. On a tie, the other port wins. The pointer updates only on a grant.
- **MEM_ARB_RR_EN undefined:** fixed priority, data over fetch, as described above; no pointer register.

## Test plan
- **Reset:** release rst_n, no requests -> all outputs 0; mem_we and mem_re stay 0.
- **Fetch:** RAM[0x40]=0xDEADBEEF; if_req, if_addr=0x40 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
- **Sub-word store:** RAM[0x100]=0x11223344; byte store of 0xAA at 0x102 -> mem_re in grant cycle, mem_we with 0x11AA3344 next cycle, d_rvalid the cycle after; load of 0x100 returns 0x11AA3344.
- **Contention:** if_req and d_req held together for 4 cycles.
  - Fixed priority: 4 data grants, 0 fetch grants.
  - MEM_ARB_RR_EN: grants alternate fetch, data, fetch, data.
- **Misaligned:** half store to 0x201 -> d_gnt; no mem_we; next cycle d_rvalid=1, d_err=1; RAM unchanged.
- **Reset mid-RMW:** assert rst_n low during RMW_WR of a half store to 0x300 -> mem_we drops at once; RAM[0x300] keeps its old value; no d_rvalid.
